// File: rtl/bcd_pkg.sv
// Shared BCD digit types and limits, common to the digit source and the decoder stage.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Out-of-range load values (10..15) collapse to zero so the digit stays legal BCD.
  function automatic bcd_t bcd_clamp_load(input bcd_t v);
    return (v <= BCD_MAX) ? v : BCD_MIN;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability-count debouncer and
// rising-edge detector.
//   clk            system clock
//   rst            synchronous active-high reset
//   raw_i          raw asynchronous button, high = pressed
//   level_o        debounced button level (registered)
//   rise_pulse_c_o one-cycle pulse in the cycle after level_o rises (decoded from flops)
module button_debounce #(
  parameter int unsigned DB_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_pulse_c_o
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o        = level_q;
  assign rise_pulse_c_o = level_q & ~prev_q;

endmodule

// File: rtl/bcd_digit_source.sv
// BCD digit generator feeding the seven-segment decoder: a registered 0..9 digit
// advanced by a prescaled auto tick or a debounced push-button step, with
// synchronous load, up/down direction and a one-cycle wrap carry.
//   clk       system clock
//   rst       synchronous active-high reset
//   en        enable auto-count ticks
//   dir       1 = up, 0 = down
//   step_btn  raw push-button
//   load      synchronous load strobe
//   load_val  value to load (10..15 load 0)
//   W,X,Y,Z   digit bits 0..3 (registered)
//   carry     one-cycle wrap pulse (registered)
module bcd_digit_source
  import bcd_pkg::*;
#(
  parameter int unsigned DIV       = 12000000,
  parameter int unsigned DB_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       step_btn,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       W,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       carry
);

  localparam int unsigned PW = $clog2(DIV);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick;
  logic          step;
  logic          btn_level;
  logic          adv;
  bcd_t          digit_q;
  bcd_t          digit_d;
  logic          carry_q;
  logic          carry_d;

  button_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk            (clk),
    .rst            (rst),
    .raw_i          (step_btn),
    .level_o        (btn_level),
    .rise_pulse_c_o (step)
  );

  // Prescaler: free-runs 0..DIV-1 while enabled, parked at zero otherwise.
  always_comb begin
    tick    = en && (presc_q == PW'(DIV - 1));
    presc_d = '0;
    if (en && !tick) begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Coincident tick and step still count as a single advance.
  assign adv = tick | step;

  // Digit update: load beats advance; carry only on a wrap.
  always_comb begin
    digit_d = digit_q;
    carry_d = 1'b0;
    if (load) begin
      digit_d = bcd_clamp_load(bcd_t'(load_val));
    end else if (adv) begin
      if (dir) begin
        if (digit_q >= BCD_MAX) begin
          digit_d = BCD_MIN;
          carry_d = 1'b1;
        end else begin
          digit_d = digit_q + bcd_t'(1);
        end
      end else begin
        if (digit_q == BCD_MIN) begin
          digit_d = BCD_MAX;
          carry_d = 1'b1;
        end else begin
          digit_d = digit_q - bcd_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      digit_q <= BCD_MIN;
      carry_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      carry_q <= carry_d;
    end
  end

  assign W     = digit_q[0];
  assign X     = digit_q[1];
  assign Y     = digit_q[2];
  assign Z     = digit_q[3];
  assign carry = carry_q;

endmodule

// File: tb/tb_bcd_digit_source.sv
module tb_bcd_digit_source;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  logic       step_btn;
  logic       load;
  logic [3:0] load_val;
  logic       W, X, Y, Z, carry;
  logic [3:0] dig;

  int checks;
  int errors;

  bcd_digit_source #(
    .DIV       (4),
    .DB_CYCLES (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .step_btn (step_btn),
    .load     (load),
    .load_val (load_val),
    .W        (W),
    .X        (X),
    .Y        (Y),
    .Z        (Z),
    .carry    (carry)
  );

  assign dig = {Z, Y, X, W};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; dir = 1'b1; step_btn = 1'b0; load = 1'b0; load_val = 4'd0;
    cyc();
    cyc();
    checks++;
    if (dig !== 4'd0) begin
      errors++; $display("FAIL reset_digit got %0d want 0", dig);
    end
    checks++;
    if (carry !== 1'b0) begin
      errors++; $display("FAIL reset_carry got %b want 0", carry);
    end
    rst = 1'b0;
    cyc();
  endtask

  // 40 cycles of auto up-count: digit steps every 4 cycles, carry only at cycle 40.
  task automatic test_auto_count();
    logic [3:0] exp_d;
    logic       exp_c;
    en = 1'b1; dir = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      exp_d = 4'((k / 4) % 10);
      exp_c = (k == 40);
      checks++;
      if (dig !== exp_d) begin
        errors++; $display("FAIL auto_digit cyc %0d got %0d want %0d", k, dig, exp_d);
      end
      checks++;
      if (carry !== exp_c) begin
        errors++; $display("FAIL auto_carry cyc %0d got %b want %b", k, carry, exp_c);
      end
    end
    en = 1'b0;
    cyc();
  endtask

  task automatic test_load();
    load = 1'b1; load_val = 4'd7;
    cyc();
    checks++;
    if (dig !== 4'd7 || carry !== 1'b0) begin
      errors++; $display("FAIL load_7 got %0d/%b want 7/0", dig, carry);
    end
    load_val = 4'd12;
    cyc();
    checks++;
    if (dig !== 4'd0) begin
      errors++; $display("FAIL load_12 got %0d want 0", dig);
    end
    load = 1'b0;
    // Load of 9 lands on the same edge as a tick: 9 must win, no carry.
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      checks++;
      if (dig !== 4'd0) begin
        errors++; $display("FAIL load_pre_tick cyc %0d got %0d want 0", k, dig);
      end
    end
    load = 1'b1; load_val = 4'd9;
    cyc();
    checks++;
    if (dig !== 4'd9 || carry !== 1'b0) begin
      errors++; $display("FAIL load_vs_tick got %0d/%b want 9/0", dig, carry);
    end
    load = 1'b0; en = 1'b0;
    cyc();
  endtask

  task automatic test_count_down();
    load = 1'b1; load_val = 4'd0;
    cyc();
    load = 1'b0; dir = 1'b0; en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 4) begin
        checks++;
        if (dig !== 4'd9 || carry !== 1'b1) begin
          errors++; $display("FAIL down_wrap got %0d/%b want 9/1", dig, carry);
        end
      end
      if (k == 5) begin
        checks++;
        if (dig !== 4'd9 || carry !== 1'b0) begin
          errors++; $display("FAIL down_carry_clear got %0d/%b want 9/0", dig, carry);
        end
      end
      if (k == 8) begin
        checks++;
        if (dig !== 4'd8 || carry !== 1'b0) begin
          errors++; $display("FAIL down_9_to_8 got %0d/%b want 8/0", dig, carry);
        end
      end
    end
    en = 1'b0; dir = 1'b1;
    cyc();
  endtask

  // A 2-cycle bounce must not survive the 3-cycle debounce.
  task automatic test_bounce();
    step_btn = 1'b1;
    cyc();
    cyc();
    step_btn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      checks++;
      if (dig !== 4'd8) begin
        errors++; $display("FAIL bounce cyc %0d got %0d want 8", k, dig);
      end
    end
  endtask

  // Clean press: one increment 6 cycles after press; release is silent.
  task automatic test_button();
    logic [3:0] exp_d;
    step_btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 10) step_btn = 1'b0;
      exp_d = (k >= 6) ? 4'd9 : 4'd8;
      checks++;
      if (dig !== exp_d || carry !== 1'b0) begin
        errors++; $display("FAIL button cyc %0d got %0d/%b want %0d/0", k, dig, carry, exp_d);
      end
    end
  endtask

  // Press timed so the step lands on the same edge as the second tick.
  task automatic test_back_to_back();
    load = 1'b1; load_val = 4'd3;
    cyc();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 2) step_btn = 1'b1;
      if (k == 4) begin
        checks++;
        if (dig !== 4'd4) begin
          errors++; $display("FAIL coinc_first_tick got %0d want 4", dig);
        end
      end
      if (k == 8 || k == 9) begin
        checks++;
        if (dig !== 4'd5) begin
          errors++; $display("FAIL coinc_single_adv cyc %0d got %0d want 5", k, dig);
        end
      end
    end
    en = 1'b0; step_btn = 1'b0;
    for (int k = 0; k < 8; k++) cyc();
  endtask

  // Reset with digit 5, prescaler at 2 and a debounce count running.
  task automatic test_reset_mid();
    step_btn = 1'b1;
    cyc();
    en = 1'b1;
    cyc();
    cyc();
    rst = 1'b1; step_btn = 1'b0;
    cyc();
    checks++;
    if (dig !== 4'd0 || carry !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %0d/%b want 0/0", dig, carry);
    end
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (k == 4) en = 1'b0;
      checks++;
      if (dig !== ((k >= 4) ? 4'd1 : 4'd0)) begin
        errors++; $display("FAIL post_reset cyc %0d got %0d want %0d", k, dig, (k >= 4) ? 1 : 0);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_auto_count();
    test_load();
    test_count_down();
    test_bounce();
    test_button();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_digit_source.md
Name: bcd_digit_source

Overview:
- Upstream stage of the 4-input seven-segment decoder: generates the BCD digit it consumes, on W (bit0, LSB), X (bit1), Y (bit2) and Z (bit3, MSB).
- Holds a registered 0..9 digit.
- The digit advances on a prescaled time tick (auto mode) or a debounced push-button step.
- The digit supports synchronous load and up/down direction, and emits a one-cycle carry/borrow on wrap.

Parameters:
- DIV, 12000000, system clocks per auto-count tick (1 Hz at 12 MHz); legal range 2..2^24.
- DB_CYCLES, 240000, clocks the synchronized button must stay stable before it is accepted (20 ms at 12 MHz); legal range 1..2^20.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  1 = auto-count on prescaler ticks; 0 = prescaler held at 0, no ticks.
- dir  input  1  1 = count up, 0 = count down; applies to both ticks and steps.
- step_btn  input  1  raw asynchronous push-button, high = pressed.
- load  input  1  synchronous load strobe.
- load_val  input  4  value written on load.
- W  output  1  digit bit0.
- X  output  1  digit bit1.
- Y  output  1  digit bit2.
- Z  output  1  digit bit3.
- carry  output  1  one-cycle pulse on wrap: 9->0 when counting up, 0->9 when counting down.

Behaviour:
- Reset (rst=1 at a clock edge) clears all of the following:
  - digit = 0, so W=X=Y=Z=0.
  - carry = 0.
  - prescaler = 0.
  - both synchronizer flops = 0.
  - debounce counter = 0.
  - debounced level = 0 (released); previous-level flop = 0.
- Reset mid-operation discards any partially counted tick or debounce in progress.
- All outputs are registered; none is combinational from inputs.
- Prescaler:
  - Counter width is $clog2(DIV).
  - While en=1 it counts 0..DIV-1 and wraps.
  - tick = 1 for the single cycle in which prescaler == DIV-1 and en=1.
  - When en=0 the prescaler is forced to 0 and tick = 0.
  - The first tick after en rises occurs exactly DIV cycles later.
- Button path:
  - step_btn passes through a 2-flop synchronizer.
  - Debouncer: when the synchronized value differs from the debounced level, the debounce counter increments. When it reaches DB_CYCLES-1 while still differing, the debounced level takes the new value and the counter clears. Any cycle where the synchronized value equals the debounced level clears the counter (so a glitch restarts the count).
  - step = 1 for the one cycle after the debounced level rises 0->1. Release produces no step.
- Advance:
  - adv = tick | step. A coincident tick and step advance the digit by exactly one.
- Digit update priority, per edge: rst > load > adv > hold.
- load=1:
  - digit <= load_val when load_val <= 9; values 10..15 load 0.
  - carry <= 0; any coincident adv is dropped.
- adv=1 with dir=1:
  - digit 0..8 -> +1, carry 0.
  - 9 -> 0 with carry 1.
- adv=1 with dir=0:
  - digit 1..9 -> -1, carry 0.
  - 0 -> 9 with carry 1.
- carry is 0 on every cycle without a wrap.
- The digit never holds 10..15 (invariant for assertions).
- Latency:
  - load to W..Z: 1 cycle.
  - tick to W..Z: 1 cycle.
  - Press to step pulse: 2 (sync) + DB_CYCLES (debounce) + 1 (edge detect) cycles; step to W..Z: 1 cycle.
- dir changes take effect on the next adv with no pipeline skew.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_MIN = 4'd0
  - typedef logic [3:0] bcd_t, shared with the decoder stage.
- Sub-module button_debounce (clk, rst, DB_CYCLES; raw in, level and rise_pulse out): contains the synchronizer, debounce counter and rising-edge detect.
- Prescaler, counter and carry logic stay in the top module.

Test Plan (DIV=4, DB_CYCLES=3 in bench):
- Reset then en=1, dir=1 for 40 cycles -> W..Z steps 0,1,..,9,0 once every 4 cycles; carry=1 for exactly the single cycle the digit becomes 0 (cycle 40); first change 4 cycles after en rises.
- Load precedence:
  - load=1, load_val=7 -> digit 7 next cycle.
  - load_val=12 -> digit 0.
  - load coincident with tick -> load value wins, no carry.
- dir=0 from digit 0 with one tick -> digit 9, carry pulses one cycle; a further tick -> 8, carry 0.
- Button:
  - step_btn high for 2 cycles (a bounce) -> no step.
  - High for 10 cycles -> exactly one increment, 6 cycles after the press (2 sync + 3 debounce + 1 edge); release gives no change.
- Coincident step and tick, with en=1 and a press timed so step and tick land on the same cycle -> digit advances by one, not two.
- rst asserted mid-count (digit 5, prescaler 2, debounce in progress) -> next cycle all outputs 0; the next tick comes 4 cycles after rst deasserts; no stale step pulse.
